// File: rtl/bram_ctrl_pkg.sv
// bram_ctrl_pkg -- shared types and constants for the word-to-byte BRAM port
// controller.
//   state_t     : controller FSM states
//   BRAM_AW     : byte-port address width
//   BRAM_DW     : byte-port data width
//   WORD_BYTES  : bytes per word request
//   WORD_W      : word data width
//   ADDR_ALIGN_MASK : clears the byte-in-word bits of a request address
package bram_ctrl_pkg;

   localparam int BRAM_AW    = 12;
   localparam int BRAM_DW    = 8;
   localparam int WORD_BYTES = 4;
   localparam int WORD_W     = BRAM_DW * WORD_BYTES;
   localparam int KW         = $clog2(WORD_BYTES);

   localparam logic [BRAM_AW-1:0] ADDR_ALIGN_MASK = ~BRAM_AW'(WORD_BYTES - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DRAIN  = 2'd2,
      RESP   = 2'd3
   } state_t;

endpackage

// File: rtl/bram_word_port_ctrl.sv
// bram_word_port_ctrl -- turns one 32-bit word request into four sequential
// accesses on an 8-bit synchronous BRAM port (1-cycle read latency), then
// returns a single response.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   req_we, req_addr,          write flag, byte address, little-endian data,
//   req_wdata, req_wstrb       per-byte write enables
//   rsp_valid/rsp_ready        response handshake (held until consumed)
//   rsp_rdata, rsp_err         read data (0 for writes), misalign error
//   bram_en, bram_we,          byte-port controls toward the external BRAM
//   bram_addr, bram_din
//   bram_dout                  byte-port read data, one cycle after access
//
// Build option
//   BRAM_CTRL_MISALIGN_CHK_EN  when defined, a request whose addr[1:0] != 0 is
//                              answered immediately with rsp_err = 1 and no
//                              BRAM access; otherwise addr[1:0] is ignored and
//                              rsp_err is tied low.
module bram_word_port_ctrl
   import bram_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic               req_we,
   input  logic [BRAM_AW-1:0] req_addr,
   input  logic [WORD_W-1:0]  req_wdata,
   input  logic [WORD_BYTES-1:0] req_wstrb,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [WORD_W-1:0]  rsp_rdata,
   output logic               rsp_err,
   output logic               bram_en,
   output logic               bram_we,
   output logic [BRAM_AW-1:0] bram_addr,
   output logic [BRAM_DW-1:0] bram_din,
   input  logic [BRAM_DW-1:0] bram_dout
);

   state_t                  state_q, state_d;
   logic [BRAM_AW-1:0]      base_q;
   logic                    we_q;
   logic [WORD_W-1:0]       wdata_q;
   logic [WORD_BYTES-1:0]   wstrb_q;
   logic [WORD_W-1:0]       rdata_q;
   logic [KW-1:0]           k_q;
   logic [KW-1:0]           cap_idx;
   logic                    accept;
   logic                    misalign;
   logic                    cap_en;

   assign accept = req_valid && (state_q == IDLE);

`ifdef BRAM_CTRL_MISALIGN_CHK_EN
   logic err_q;
   assign misalign = (req_addr & ~ADDR_ALIGN_MASK) != '0;
`else
   assign misalign = 1'b0;
`endif

   // Byte k is returned by the BRAM during the cycle after it was issued.
   // k_q has already advanced by then, so the byte being returned is k_q-1;
   // in DRAIN k_q has wrapped to 0 and k_q-1 lands on byte 3.
   assign cap_idx = k_q - KW'(1);
   assign cap_en  = !we_q && (((state_q == ACCESS) && (k_q != '0)) ||
                              (state_q == DRAIN));

   // ---------------- next-state ----------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (accept) state_d = misalign ? RESP : ACCESS;
         end
         ACCESS: begin
            if (k_q == KW'(WORD_BYTES - 1)) state_d = we_q ? RESP : DRAIN;
         end
         DRAIN:   state_d = RESP;
         RESP: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // ---------------- datapath ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         wstrb_q <= '0;
         rdata_q <= '0;
         k_q     <= '0;
      end else begin
         if (accept) begin
            base_q  <= req_addr & ADDR_ALIGN_MASK;
            we_q    <= req_we;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
            rdata_q <= '0;   // writes and errored requests respond with 0
            k_q     <= '0;
         end else if (state_q == ACCESS) begin
            k_q <= k_q + KW'(1);
         end
         if (cap_en) rdata_q[cap_idx*BRAM_DW +: BRAM_DW] <= bram_dout;
      end
   end

`ifdef BRAM_CTRL_MISALIGN_CHK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      err_q <= 1'b0;
      else if (accept) err_q <= misalign;
   end
   assign rsp_err = (state_q == RESP) && err_q;
`else
   assign rsp_err = 1'b0;
`endif

   // ---------------- outputs ----------------
   // Port outputs are decoded from state so that an asynchronous reset
   // drops bram_en in the same instant, without waiting for a clock edge.
   always_comb begin
      req_ready = (state_q == IDLE);
      rsp_valid = (state_q == RESP);
      rsp_rdata = (state_q == RESP) ? rdata_q : '0;
      bram_en   = 1'b0;
      bram_we   = 1'b0;
      bram_addr = '0;
      bram_din  = '0;
      if (state_q == ACCESS) begin
         bram_en   = 1'b1;
         bram_addr = base_q + BRAM_AW'(k_q);
         if (we_q) begin
            bram_we  = wstrb_q[k_q];
            bram_din = wdata_q[k_q*BRAM_DW +: BRAM_DW];
         end
      end
   end

endmodule

// File: tb/tb_bram_word_port_ctrl.sv
// tb_bram_word_port_ctrl -- self-checking bench for bram_word_port_ctrl.
// A byte-array BRAM model sits on the byte port; a separate word-level
// reference memory predicts every response from the request rules alone.
module tb_bram_word_port_ctrl;

   logic        clk;
   logic        rst_n;
   logic        req_valid, req_ready, req_we;
   logic [11:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_wstrb;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdata;
   logic        bram_en, bram_we;
   logic [11:0] bram_addr;
   logic [7:0]  bram_din, bram_dout;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0]  mem     [4096];   // the physical BRAM
   logic [7:0]  ref_mem [4096];   // what memory should hold
   logic [20:0] acc_log [$];      // {we, addr, din} of every enabled access

   bram_word_port_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_wstrb (req_wstrb),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .bram_en   (bram_en),
      .bram_we   (bram_we),
      .bram_addr (bram_addr),
      .bram_din  (bram_din),
      .bram_dout (bram_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // synchronous read-first byte BRAM
   always @(posedge clk) begin
      if (bram_en) begin
         if (bram_we) mem[bram_addr] <= bram_din;
         bram_dout <= mem[bram_addr];
         acc_log.push_back({bram_we, bram_addr, bram_din});
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bit is_misaligned(input logic [11:0] a);
`ifdef BRAM_CTRL_MISALIGN_CHK_EN
      return a[1:0] != 2'b00;
`else
      return 1'b0;
`endif
   endfunction

   // One complete request/response, checked against the reference memory.
   task automatic xact(input logic we, input logic [11:0] addr, input logic [31:0] wd,
                       input logic [3:0] ws, input int hold);
      logic [11:0] base;
      bit          mis;
      int          lat, exp_lat;
      logic [31:0] exp_rd, first_rd;
      logic [20:0] e;
      base = {addr[11:2], 2'b00};
      mis  = is_misaligned(addr);
      exp_rd = 32'h0;
      if (!we && !mis)
         exp_rd = {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
      if (we && !mis)
         for (int i = 0; i < 4; i++)
            if (ws[i]) ref_mem[base+12'(i)] = wd[8*i +: 8];
      exp_lat = mis ? 1 : (we ? 5 : 6);
      acc_log.delete();

      @(negedge clk);
      chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_wstrb = ws;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_we    = $urandom_range(0, 1);
      req_addr  = 12'($urandom);
      req_wdata = $urandom;
      req_wstrb = 4'($urandom);

      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!rsp_valid && lat < 20);
      chk("latency", lat, exp_lat);
      chk("rsp_rdata", rsp_rdata, exp_rd);
      chk("rsp_err", {31'b0, rsp_err}, {31'b0, mis});
      first_rd = rsp_rdata;

      // back-pressure: response must hold and new requests must be ignored
      for (int h = 0; h < hold; h++) begin
         req_valid = 1'b1;
         @(negedge clk);
         chk("hold_valid", {31'b0, rsp_valid}, 32'd1);
         chk("hold_rdata", rsp_rdata, first_rd);
         chk("hold_ready", {31'b0, req_ready}, 32'd0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      @(negedge clk);
      chk("ready_after_rsp", {31'b0, req_ready}, 32'd1);
      chk("valid_after_rsp", {31'b0, rsp_valid}, 32'd0);

      chk("num_access", acc_log.size(), mis ? 0 : 4);
      if (!mis && acc_log.size() == 4)
         for (int i = 0; i < 4; i++) begin
            e = acc_log[i];
            chk("acc_addr", {20'b0, e[19:8]}, {20'b0, base + 12'(i)});
            chk("acc_we", {31'b0, e[20]}, {31'b0, we & ws[i]});
            if (we) chk("acc_din", {24'b0, e[7:0]}, {24'b0, wd[8*i +: 8]});
         end
   endtask

   // Reset during the second ACCESS cycle of a write: only byte 0 lands.
   task automatic reset_mid_write(input logic [11:0] base, input logic [31:0] wd,
                                  input logic [3:0] ws);
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = base; req_wdata = wd; req_wstrb = ws;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(posedge clk);              // start of 2nd ACCESS cycle
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_en", {31'b0, bram_en}, 32'd0);
      chk("rst_mid_ready", {31'b0, req_ready}, 32'd1);
      chk("rst_mid_valid", {31'b0, rsp_valid}, 32'd0);
      if (ws[0]) ref_mem[base] = wd[7:0];
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("rst_no_rsp", {31'b0, rsp_valid}, 32'd0);
      end
   endtask

   initial begin
      int diffs;
      for (int i = 0; i < 4096; i++) begin
         mem[i] = 8'h00;
         ref_mem[i] = 8'h00;
      end
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
      req_wdata = '0; req_wstrb = '0; rsp_ready = 1'b0;
      #23;
      chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
      chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
      chk("rst_bram_en", {31'b0, bram_en}, 32'd0);
      chk("rst_bram_we", {31'b0, bram_we}, 32'd0);
      chk("rst_bram_addr", {20'b0, bram_addr}, 32'd0);
      chk("rst_bram_din", {24'b0, bram_din}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // directed cases
      xact(1'b1, 12'h010, 32'hDDCCBBAA, 4'hF, 0);
      xact(1'b0, 12'h010, 32'h0, 4'h0, 0);
      chk("readback_0x010", {mem[12'h013], mem[12'h012], mem[12'h011], mem[12'h010]}, 32'hDDCCBBAA);
      xact(1'b1, 12'hFFC, 32'h55667788, 4'hF, 0);
      xact(1'b1, 12'hFFC, 32'h11223344, 4'h5, 0);
      xact(1'b0, 12'hFFC, 32'h0, 4'h0, 0);
      chk("strobe_0xFFC", {mem[12'hFFF], mem[12'hFFE], mem[12'hFFD], mem[12'hFFC]}, 32'h55227744);
      chk("no_wrap_0x000", {24'b0, mem[12'h000]}, 32'd0);
      xact(1'b0, 12'h010, 32'h0, 4'h0, 10);
      xact(1'b1, 12'h020, 32'hCAFEF00D, 4'h0, 2);
      xact(1'b0, 12'h013, 32'h0, 4'h0, 1);
      xact(1'b1, 12'h011, 32'h01020304, 4'hF, 0);
      reset_mid_write(12'h040, 32'h44332211, 4'hF);
      xact(1'b0, 12'h040, 32'h0, 4'h0, 0);

      // randomized traffic
      for (int t = 0; t < 60; t++) begin
         logic [11:0] a;
         a = ($urandom_range(0, 1) ? 12'hFE0 : 12'h000) + 12'($urandom_range(0, 7) * 4);
         if ($urandom_range(0, 3) == 0) a = a + 12'($urandom_range(1, 3));
         xact(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), $urandom_range(0, 3));
      end

      diffs = 0;
      for (int i = 0; i < 4096; i++)
         if (mem[i] !== ref_mem[i]) diffs++;
      chk("mem_contents", diffs, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/bram_word_port_ctrl.md
BRAM_WORD_PORT_CTRL -- requirements
Module: bram_word_port_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 clk  input  1  rising-edge clock for all state; the same clock as the attached BRAM port.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 req_valid  input  1  word request present.
REQ-005 req_ready  output  1  request accepted when high together with req_valid.
REQ-006 req_we  input  1  1 = write, 0 = read.
REQ-007 req_addr  input  12  byte address; word-aligned when bits [1:0] = 0.
REQ-008 req_wdata  input  32  write data, little-endian.
REQ-009 req_wstrb  input  4  byte write enables; bit k enables byte k.
REQ-010 rsp_valid  output  1  response present.
REQ-011 rsp_ready  input  1  response consumed when high together with rsp_valid.
REQ-012 rsp_rdata  output  32  assembled read data; 0 for writes.
REQ-013 rsp_err  output  1  misaligned-request error flag.
REQ-014 bram_en  output  1  byte port enable.
REQ-015 bram_we  output  1  byte port write enable.
REQ-016 bram_addr  output  12  byte port address.
REQ-017 bram_din  output  8  byte port write data.
REQ-018 bram_dout  input  8  byte port read data, valid one cycle after an enabled access.

Function
REQ-019 The FSM SHALL have four states: IDLE, ACCESS, DRAIN and RESP.
REQ-020 req_ready SHALL be 1 only in IDLE; all other states SHALL ignore req_*.
REQ-021 On acceptance, the block SHALL latch the address with [1:0] forced to 0, together with we, wdata and wstrb, and go to ACCESS with byte counter k = 0.
REQ-022 ACCESS SHALL run 4 consecutive cycles with bram_en = 1 and bram_addr = base + k, for k = 0..3; addresses SHALL NOT wrap, because base is at most 0xFFC.
REQ-023 For writes, bram_we SHALL equal wstrb[k] and bram_din SHALL equal wdata[8k+7:8k].
REQ-024 For reads, bram_we SHALL be 0, and bram_dout SHALL be captured into rdata[8k+7:8k] one cycle after byte k is issued.
REQ-025 A read SHALL go ACCESS -> DRAIN, capturing byte 3 in DRAIN with bram_en = 0, then -> RESP.
REQ-026 A write SHALL go ACCESS -> RESP directly.
REQ-027 Latency from the accept edge to rsp_valid SHALL be 6 cycles for a read and 5 cycles for a write.
REQ-028 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL hold stable until rsp_ready = 1; the block SHALL then return to IDLE.
REQ-029 req_ready SHALL rise in the cycle after the response handshake; there SHALL be no back-to-back overlap.
REQ-030 A write with wstrb = 0 SHALL still take 4 ACCESS cycles with bram_we = 0 and SHALL respond normally.
REQ-031 bram_en and bram_we SHALL be 0 in IDLE, DRAIN and RESP.

Reset
REQ-032 While rst_n = 0, the block SHALL hold: state IDLE, req_ready 1, rsp_valid 0, rsp_rdata 0, rsp_err 0, bram_en 0, bram_we 0, bram_addr 0, bram_din 0.
REQ-033 Reset mid-transfer SHALL abort the transfer with no response; bytes already written SHALL remain written.

Configuration
REQ-034 The block SHALL support one macro, BRAM_CTRL_MISALIGN_CHK_EN.
REQ-035 With BRAM_CTRL_MISALIGN_CHK_EN defined, a request with addr[1:0] != 0 SHALL go IDLE -> RESP with rsp_err = 1, rsp_rdata = 0 and no BRAM access.
REQ-036 Without BRAM_CTRL_MISALIGN_CHK_EN, addr[1:0] SHALL be ignored and rsp_err SHALL be tied to 0.

Structure
REQ-037 A shared package, bram_ctrl_pkg, SHALL hold the state enum and the constants BRAM_AW = 12, BRAM_DW = 8 and WORD_BYTES = 4.
REQ-038 The block SHALL be a single module with no sub-module; the BRAM itself is instantiated outside the block.

Verification
REQ-039 Write 0x0010 with wdata 0xDDCCBBAA and wstrb 0xF -> bram writes 0xAA, 0xBB, 0xCC, 0xDD at 0x010..0x013; rsp_valid at accept + 5.
REQ-040 Read back 0x0010 -> rsp_rdata 0xDDCCBBAA at accept + 6, rsp_err 0.
REQ-041 Write 0x0FFC with 0x11223344 and wstrb 0x5, then read 0x0FFC -> bytes 0xFFC and 0xFFE updated only; the other two bytes keep their prior contents, with no address wrap.
REQ-042 Hold rsp_ready = 0 for 10 cycles -> rsp_valid and rsp_rdata stay stable, req_ready stays 0, and a new req_valid is not accepted.
REQ-043 Request 0x0013 -> with BRAM_CTRL_MISALIGN_CHK_EN: rsp_err 1 at accept + 1, bram_en never asserted; without it: a normal read of 0x010..0x013.
REQ-044 Deassert rst_n in the 2nd ACCESS cycle of a write -> bram_en falls immediately, no response is produced, and the next request completes normally.
